// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// A slot mirrors one in-flight instruction downstream of decode.
package pipe_ctrl_pkg;

  localparam int DEPTH_DEF     = 3;
  localparam int REG_AW_DEF    = 5;
  localparam bit FWD_EN_DEF    = 1'b1;
  localparam bit RF_BYPASS_DEF = 1'b1;
  localparam int CNT_W_DEF     = 32;

  // Register tags are stored at a fixed width so the slot struct can live here;
  // narrower REG_AW values are zero-extended on entry.
  localparam int REG_AW_MAX = 8;

  localparam int FWD_NONE = 0;

  typedef logic [REG_AW_MAX-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     wr;
    logic     load;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     rs1_used;
    logic     rs2_used;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // x0 is hard-wired, so a write to it never produces a value anyone can depend on.
  function automatic logic is_producer(input slot_t s);
    return s.valid && s.wr && (s.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_src_match.sv
// Youngest-match priority encoder: finds the lowest eligible slot whose
// destination tag equals a used, non-zero source tag.
module pipe_src_match
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [REG_AW_MAX-1:0]            rs_i,
  input  logic                             used_i,
  input  logic [DEPTH-1:0][REG_AW_MAX-1:0] rd_i,
  input  logic [DEPTH-1:0]                 elig_i,
  output logic                             hit_o,
  output logic [IDX_W-1:0]                 idx_o
);

  // Scan oldest to youngest so the lowest matching index is left standing.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used_i && (rs_i != '0) && elig_i[k] && (rd_i[k] == rs_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the in-order core: shadow chain of in-flight tags,
// RAW hazard stalls, redirect flushes, EX forwarding selects and perf counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter bit FWD_EN    = FWD_EN_DEF,
  parameter bit RF_BYPASS = RF_BYPASS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs1,
  input  logic [REG_AW-1:0]        id_rs2,
  input  logic                     id_rs1_used,
  input  logic                     id_rs2_used,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_reg_wr,
  input  logic                     id_is_load,
  input  logic                     ex_busy,
  input  logic                     ex_redirect,
  output logic                     pc_en,
  output logic                     if_id_en,
  output logic                     if_id_flush,
  output logic                     id_ex_bubble,
  output logic                     hazard_stall,
  output logic [$clog2(DEPTH)-1:0] fwd_sel_a,
  output logic [$clog2(DEPTH)-1:0] fwd_sel_b,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         flush_count
);

  localparam int IDX_W = $clog2(DEPTH);

  slot_t slots_q [DEPTH];
  slot_t slots_d [DEPTH];
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  slot_t idEntry;
  logic [REG_AW_MAX-1:0] idRs1, idRs2;
  logic [DEPTH-1:0][REG_AW_MAX-1:0] slotRd;
  logic [DEPTH-1:0] hazElig, fwdElig;
  logic hazHitA, hazHitB, fwdHitA, fwdHitB;
  logic [IDX_W-1:0] hazIdxA, hazIdxB, fwdIdxA, fwdIdxB;
  logic hazard, redirectTaken;

  assign idRs1 = REG_AW_MAX'(id_rs1);
  assign idRs2 = REG_AW_MAX'(id_rs2);

  always_comb begin
    idEntry          = SLOT_BUBBLE;
    idEntry.valid    = 1'b1;
    idEntry.rd       = REG_AW_MAX'(id_rd);
    idEntry.wr       = id_reg_wr;
    idEntry.load     = id_is_load;
    idEntry.rs1      = idRs1;
    idEntry.rs2      = idRs2;
    idEntry.rs1_used = id_rs1_used;
    idEntry.rs2_used = id_rs2_used;
  end

  // With forwarding only a load still in EX can block decode; without it every
  // live producer does, except the one writing back into a write-first file.
  always_comb begin
    slotRd  = '0;
    hazElig = '0;
    fwdElig = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slotRd[k] = slots_q[k].rd;
      if (FWD_EN) begin
        hazElig[k] = (k == 0) && is_producer(slots_q[k]) && slots_q[k].load;
        fwdElig[k] = (k != 0) && is_producer(slots_q[k]);
      end else begin
        hazElig[k] = is_producer(slots_q[k]) && !(RF_BYPASS && (k == DEPTH - 1));
      end
    end
  end

  pipe_src_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) uHazA (
    .rs_i(idRs1), .used_i(id_rs1_used), .rd_i(slotRd), .elig_i(hazElig),
    .hit_o(hazHitA), .idx_o(hazIdxA)
  );

  pipe_src_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) uHazB (
    .rs_i(idRs2), .used_i(id_rs2_used), .rd_i(slotRd), .elig_i(hazElig),
    .hit_o(hazHitB), .idx_o(hazIdxB)
  );

  pipe_src_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) uFwdA (
    .rs_i(slots_q[0].rs1), .used_i(slots_q[0].valid && slots_q[0].rs1_used),
    .rd_i(slotRd), .elig_i(fwdElig), .hit_o(fwdHitA), .idx_o(fwdIdxA)
  );

  pipe_src_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) uFwdB (
    .rs_i(slots_q[0].rs2), .used_i(slots_q[0].valid && slots_q[0].rs2_used),
    .rd_i(slotRd), .elig_i(fwdElig), .hit_o(fwdHitB), .idx_o(fwdIdxB)
  );

  // The hazard encoders only need to report a hit; which slot matched is irrelevant.
  logic unusedHazIdx;
  assign unusedHazIdx = ^{hazIdxA, hazIdxB};

  assign hazard    = id_valid && (hazHitA || hazHitB);
  assign fwd_sel_a = fwdHitA ? fwdIdxA : IDX_W'(FWD_NONE);
  assign fwd_sel_b = fwdHitB ? fwdIdxB : IDX_W'(FWD_NONE);

  // A busy EX freezes the front end outright; a redirect discards the
  // wrong-path decode, so it overrides any hazard that decode would raise.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    hazard_stall  = 1'b0;
    redirectTaken = 1'b0;
    if (ex_busy) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (ex_redirect) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      redirectTaken = 1'b1;
    end else if (hazard) begin
      hazard_stall = 1'b1;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // While EX is busy its instruction stays in slot 0 and a bubble opens behind it.
  always_comb begin
    for (int k = 1; k < DEPTH; k++) begin
      slots_d[k] = slots_q[k-1];
    end
    slots_d[0] = SLOT_BUBBLE;
    if (ex_busy) begin
      slots_d[0] = slots_q[0];
      slots_d[1] = SLOT_BUBBLE;
    end else if (!ex_redirect && !hazard && id_valid) begin
      slots_d[0] = idEntry;
    end
  end

  assign stallCnt_d = stallCnt_q + CNT_W'(hazard_stall | ex_busy);
  assign flushCnt_d = flushCnt_q + CNT_W'(redirectTaken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        slots_q[k] <= SLOT_BUBBLE;
      end
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slots_q[k] <= slots_d[k];
      end
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cycles = stallCnt_q;
  assign flush_count  = flushCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded bench for pipe_hazard_ctrl: one forwarding instance and two
// non-forwarding instances (with and without register-file bypass) share stimulus.
module tb_pipe_hazard_ctrl;

  logic clk, rst;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_is_load, ex_busy, ex_redirect;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic pcEn0, ifIdEn0, ifIdFlush0, idExBubble0, hazStall0;
  logic pcEn1, ifIdEn1, ifIdFlush1, idExBubble1, hazStall1;
  logic pcEn2, ifIdEn2, ifIdFlush2, idExBubble2, hazStall2;
  logic [1:0] fwdA0, fwdB0, fwdA1, fwdB1, fwdA2, fwdB2;
  logic [31:0] stall0, flush0, stall1, flush1, stall2, flush2;

  int checks = 0;
  int errors = 0;

  // Control nibble order: pc_en, if_id_en, if_id_flush, id_ex_bubble, hazard_stall
  localparam logic [4:0] C_NORM  = 5'b11000;
  localparam logic [4:0] C_HAZ   = 5'b00011;
  localparam logic [4:0] C_FLUSH = 5'b11110;
  localparam logic [4:0] C_BUSY  = 5'b00000;

  typedef struct packed {
    logic valid; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic u1; logic u2; logic wr; logic ld; logic busy; logic redir;
  } stim_t;

  typedef struct { string tag; int sel; logic [8:0] ctrl; } exp_t;
  exp_t expQ[$];

  localparam stim_t IDLE_S = '0;

  pipe_hazard_ctrl uDutFwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .ex_busy(ex_busy),
    .ex_redirect(ex_redirect), .pc_en(pcEn0), .if_id_en(ifIdEn0),
    .if_id_flush(ifIdFlush0), .id_ex_bubble(idExBubble0), .hazard_stall(hazStall0),
    .fwd_sel_a(fwdA0), .fwd_sel_b(fwdB0), .stall_cycles(stall0), .flush_count(flush0)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .RF_BYPASS(1'b1)) uDutNoFwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .ex_busy(ex_busy),
    .ex_redirect(ex_redirect), .pc_en(pcEn1), .if_id_en(ifIdEn1),
    .if_id_flush(ifIdFlush1), .id_ex_bubble(idExBubble1), .hazard_stall(hazStall1),
    .fwd_sel_a(fwdA1), .fwd_sel_b(fwdB1), .stall_cycles(stall1), .flush_count(flush1)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .RF_BYPASS(1'b0)) uDutNoFwdNoByp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .ex_busy(ex_busy),
    .ex_redirect(ex_redirect), .pc_en(pcEn2), .if_id_en(ifIdEn2),
    .if_id_flush(ifIdFlush2), .id_ex_bubble(idExBubble2), .hazard_stall(hazStall2),
    .fwd_sel_a(fwdA2), .fwd_sel_b(fwdB2), .stall_cycles(stall2), .flush_count(flush2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctrlOf(input int sel);
    case (sel)
      0:       ctrlOf = {pcEn0, ifIdEn0, ifIdFlush0, idExBubble0, hazStall0, fwdA0, fwdB0};
      1:       ctrlOf = {pcEn1, ifIdEn1, ifIdFlush1, idExBubble1, hazStall1, fwdA1, fwdB1};
      default: ctrlOf = {pcEn2, ifIdEn2, ifIdFlush2, idExBubble2, hazStall2, fwdA2, fwdB2};
    endcase
  endfunction

  function automatic logic [31:0] stallOf(input int sel);
    stallOf = (sel == 0) ? stall0 : (sel == 1) ? stall1 : stall2;
  endfunction

  function automatic logic [31:0] flushOf(input int sel);
    flushOf = (sel == 0) ? flush0 : (sel == 1) ? flush1 : flush2;
  endfunction

  function automatic stim_t alu(input int rd, input int rs1, input int rs2);
    stim_t s = '0;
    s.valid = 1'b1; s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    s.u1 = 1'b1; s.u2 = 1'b1; s.wr = 1'b1;
    return s;
  endfunction

  function automatic stim_t load(input int rd, input int rs1);
    stim_t s = '0;
    s.valid = 1'b1; s.rd = 5'(rd); s.rs1 = 5'(rs1);
    s.u1 = 1'b1; s.wr = 1'b1; s.ld = 1'b1;
    return s;
  endfunction

  task automatic driveCycle(input stim_t s);
    @(negedge clk);
    id_valid = s.valid; id_rd = s.rd; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_used = s.u1; id_rs2_used = s.u2; id_reg_wr = s.wr; id_is_load = s.ld;
    ex_busy = s.busy; ex_redirect = s.redir;
  endtask

  task automatic doReset();
    driveCycle(IDLE_S);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    driveCycle(IDLE_S);
    for (int s = 0; s < 3; s++) expQ.push_back('{"reset", s, {C_NORM, 4'b0000}});
    #2;
    for (int s = 0; s < 3; s++) begin
      e = expQ.pop_front();
      checks++;
      if (ctrlOf(e.sel) !== e.ctrl) begin
        errors++;
        $display("[TB] FAIL %s dut%0d ctrl: got %b expected %b", e.tag, e.sel, ctrlOf(e.sel), e.ctrl);
      end
      checks++;
      if (stallOf(s) !== 32'd0 || flushOf(s) !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset dut%0d counters: got %0d/%0d expected 0/0", s, stallOf(s), flushOf(s));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_independent();
    stim_t st[5];
    exp_t e;
    doReset();
    st[0] = alu(1, 2, 3); st[1] = alu(4, 10, 11); st[2] = alu(12, 13, 14);
    st[3] = alu(15, 16, 17); st[4] = IDLE_S;
    for (int i = 0; i < 5; i++) begin
      driveCycle(st[i]);
      for (int s = 0; s < 3; s++) expQ.push_back('{"independent", s, {C_NORM, 4'b0000}});
      #2;
      for (int s = 0; s < 3; s++) begin
        e = expQ.pop_front();
        checks++;
        if (ctrlOf(e.sel) !== e.ctrl) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d dut%0d: got %b expected %b", e.tag, i, e.sel, ctrlOf(e.sel), e.ctrl);
        end
      end
    end
    checks++;
    if (stall0 !== 32'd0 || flush0 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL independent counters: got %0d/%0d expected 0/0", stall0, flush0);
    end
  endtask

  task automatic test_forward();
    stim_t st[9];
    logic [8:0] ex[9];
    exp_t e;
    doReset();
    st[0] = alu(5, 1, 2);  ex[0] = {C_NORM, 2'd0, 2'd0};
    st[1] = alu(6, 5, 1);  ex[1] = {C_NORM, 2'd0, 2'd0};
    st[2] = alu(9, 7, 5);  ex[2] = {C_NORM, 2'd1, 2'd0};
    st[3] = IDLE_S;        ex[3] = {C_NORM, 2'd0, 2'd2};
    st[4] = IDLE_S;        ex[4] = {C_NORM, 2'd0, 2'd0};
    st[5] = alu(5, 1, 2);  ex[5] = {C_NORM, 2'd0, 2'd0};
    st[6] = alu(5, 3, 4);  ex[6] = {C_NORM, 2'd0, 2'd0};
    st[7] = alu(11, 5, 0); ex[7] = {C_NORM, 2'd0, 2'd0};
    st[8] = IDLE_S;        ex[8] = {C_NORM, 2'd1, 2'd0};
    for (int i = 0; i < 9; i++) begin
      driveCycle(st[i]);
      expQ.push_back('{"forward", 0, ex[i]});
      #2;
      e = expQ.pop_front();
      checks++;
      if (ctrlOf(e.sel) !== e.ctrl) begin
        errors++;
        $display("[TB] FAIL %s cyc%0d: got %b expected %b", e.tag, i, ctrlOf(e.sel), e.ctrl);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t st[4];
    logic [8:0] ex[4];
    exp_t e;
    doReset();
    st[0] = load(7, 1);   ex[0] = {C_NORM, 2'd0, 2'd0};
    st[1] = alu(8, 7, 7); ex[1] = {C_HAZ,  2'd0, 2'd0};
    st[2] = alu(8, 7, 7); ex[2] = {C_NORM, 2'd0, 2'd0};
    st[3] = IDLE_S;       ex[3] = {C_NORM, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      driveCycle(st[i]);
      expQ.push_back('{"load_use", 0, ex[i]});
      #2;
      e = expQ.pop_front();
      checks++;
      if (ctrlOf(e.sel) !== e.ctrl) begin
        errors++;
        $display("[TB] FAIL %s cyc%0d: got %b expected %b", e.tag, i, ctrlOf(e.sel), e.ctrl);
      end
    end
    checks++;
    if (stall0 !== 32'd1) begin
      errors++;
      $display("[TB] FAIL load_use stall_cycles: got %0d expected 1", stall0);
    end
  endtask

  task automatic test_no_forward();
    stim_t st[6];
    logic [8:0] ex1[6], ex2[6];
    exp_t e;
    doReset();
    st[0] = alu(5, 1, 2); ex1[0] = {C_NORM, 4'b0}; ex2[0] = {C_NORM, 4'b0};
    st[1] = alu(6, 5, 0); ex1[1] = {C_HAZ,  4'b0}; ex2[1] = {C_HAZ,  4'b0};
    st[2] = alu(6, 5, 0); ex1[2] = {C_HAZ,  4'b0}; ex2[2] = {C_HAZ,  4'b0};
    st[3] = alu(6, 5, 0); ex1[3] = {C_NORM, 4'b0}; ex2[3] = {C_HAZ,  4'b0};
    st[4] = alu(6, 5, 0); ex1[4] = {C_NORM, 4'b0}; ex2[4] = {C_NORM, 4'b0};
    st[5] = IDLE_S;       ex1[5] = {C_NORM, 4'b0}; ex2[5] = {C_NORM, 4'b0};
    for (int i = 0; i < 6; i++) begin
      driveCycle(st[i]);
      expQ.push_back('{"no_fwd_bypass", 1, ex1[i]});
      expQ.push_back('{"no_fwd_no_bypass", 2, ex2[i]});
      #2;
      for (int s = 0; s < 2; s++) begin
        e = expQ.pop_front();
        checks++;
        if (ctrlOf(e.sel) !== e.ctrl) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d: got %b expected %b", e.tag, i, ctrlOf(e.sel), e.ctrl);
        end
      end
    end
    checks++;
    if (stall1 !== 32'd2 || stall2 !== 32'd3) begin
      errors++;
      $display("[TB] FAIL no_fwd stall_cycles: got %0d/%0d expected 2/3", stall1, stall2);
    end
  endtask

  task automatic test_redirect();
    stim_t st[6];
    logic [8:0] ex[6];
    exp_t e;
    doReset();
    st[0] = load(7, 1);   ex[0] = {C_NORM,  4'b0};
    st[1] = alu(8, 7, 7); st[1].redir = 1'b1; ex[1] = {C_FLUSH, 4'b0};
    st[2] = IDLE_S;       ex[2] = {C_NORM,  4'b0};
    st[3] = load(0, 1);   ex[3] = {C_NORM,  4'b0};
    st[4] = alu(9, 0, 0); ex[4] = {C_NORM,  4'b0};
    st[5] = IDLE_S;       ex[5] = {C_NORM,  4'b0};
    for (int i = 0; i < 6; i++) begin
      driveCycle(st[i]);
      for (int s = 0; s < 3; s++) expQ.push_back('{"redirect", s, ex[i]});
      #2;
      for (int s = 0; s < 3; s++) begin
        e = expQ.pop_front();
        checks++;
        if (ctrlOf(e.sel) !== e.ctrl) begin
          errors++;
          $display("[TB] FAIL %s cyc%0d dut%0d: got %b expected %b", e.tag, i, e.sel, ctrlOf(e.sel), e.ctrl);
        end
      end
      if (i == 2) begin
        for (int s = 0; s < 3; s++) begin
          checks++;
          if (flushOf(s) !== 32'd1 || stallOf(s) !== 32'd0) begin
            errors++;
            $display("[TB] FAIL redirect dut%0d counters: got flush %0d stall %0d expected 1/0", s, flushOf(s), stallOf(s));
          end
        end
      end
    end
  endtask

  task automatic test_busy();
    stim_t st[10];
    logic [8:0] ex[10];
    exp_t e;
    doReset();
    st[0] = alu(5, 1, 2); ex[0] = {C_NORM, 2'd0, 2'd0};
    st[1] = alu(6, 5, 3); ex[1] = {C_NORM, 2'd0, 2'd0};
    st[2] = alu(7, 6, 6); st[2].busy = 1'b1; ex[2] = {C_BUSY, 2'd1, 2'd0};
    st[3] = st[2];        st[3].redir = 1'b1; ex[3] = {C_BUSY, 2'd2, 2'd0};
    st[4] = st[2];        ex[4] = {C_BUSY, 2'd0, 2'd0};
    st[5] = st[2];        ex[5] = {C_BUSY, 2'd0, 2'd0};
    st[6] = IDLE_S;       ex[6] = {C_NORM, 2'd0, 2'd0};
    st[7] = alu(5, 1, 2); ex[7] = {C_NORM, 2'd0, 2'd0};
    st[8] = alu(6, 5, 3); ex[8] = {C_NORM, 2'd0, 2'd0};
    st[9] = st[2];        ex[9] = {C_BUSY, 2'd1, 2'd0};
    for (int i = 0; i < 10; i++) begin
      driveCycle(st[i]);
      expQ.push_back('{"busy", 0, ex[i]});
      #2;
      e = expQ.pop_front();
      checks++;
      if (ctrlOf(e.sel) !== e.ctrl) begin
        errors++;
        $display("[TB] FAIL %s cyc%0d: got %b expected %b", e.tag, i, ctrlOf(e.sel), e.ctrl);
      end
      if (i == 6) begin
        checks++;
        if (stall0 !== 32'd4 || flush0 !== 32'd0) begin
          errors++;
          $display("[TB] FAIL busy counters: got stall %0d flush %0d expected 4/0", stall0, flush0);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (stall0 !== 32'd5) begin
      errors++;
      $display("[TB] FAIL busy pre-reset stall_cycles: got %0d expected 5", stall0);
    end
    rst = 1'b1;
    ex_busy = 1'b0; id_valid = 1'b0;
    #2;
    checks++;
    if (stall0 !== 32'd0 || flush0 !== 32'd0 || ctrlOf(0) !== {C_NORM, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL busy async reset: got stall %0d flush %0d ctrl %b", stall0, flush0, ctrlOf(0));
    end
    @(negedge clk);
    rst = 1'b0;
    ex_busy = 1'b1;
    #2;
    checks++;
    if (ctrlOf(0) !== {C_BUSY, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL busy after reset: got %b expected %b", ctrlOf(0), {C_BUSY, 4'b0000});
    end
    driveCycle(IDLE_S);
    #2;
    checks++;
    if (stall0 !== 32'd1 || ctrlOf(0) !== {C_NORM, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL busy post-reset: got stall %0d ctrl %b expected 1 and %b", stall0, ctrlOf(0), {C_NORM, 4'b0000});
    end
  endtask

  initial begin
    rst = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_wr = 1'b0; id_is_load = 1'b0;
    ex_busy = 1'b0; ex_redirect = 1'b0;
    $display("[TB] starting pipe_hazard_ctrl bench");
    test_reset();
    test_independent();
    test_forward();
    test_load_use();
    test_no_forward();
    test_redirect();
    test_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
